// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and helpers for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // Operation codes; 0-7 match the legacy md_control encoding.
  typedef enum logic [3:0] {
    READ_HI  = 4'd0,
    READ_LO  = 4'd1,
    WRITE_HI = 4'd2,
    WRITE_LO = 4'd3,
    SMUL     = 4'd4,
    UMUL     = 4'd5,
    SDIV     = 4'd6,
    UDIV     = 4'd7,
    SMADD    = 4'd8,
    UMADD    = 4'd9,
    SMSUB    = 4'd10,
    UMSUB    = 4'd11
  } mdu_op_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

  // True for operations that occupy the unit for a latency period.
  function automatic logic is_compute(mdu_op_t op);
    return op inside {SMUL, UMUL, SDIV, UDIV, SMADD, UMADD, SMSUB, UMSUB};
  endfunction

  // True for operations charged the divide latency.
  function automatic logic is_div(mdu_op_t op);
    return op inside {SDIV, UDIV};
  endfunction

  // True for operations that treat operands as two's complement.
  function automatic logic is_signed_op(mdu_op_t op);
    return op inside {SMUL, SDIV, SMADD, SMSUB};
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_if
// Description : Request/response bundle between the EX stage and the MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  mdu_op_t          operation;
  logic             start;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Pipeline side: issues requests, observes status and read data.
  modport master (
    output op_a, op_b, operation, start, cancel,
    input  busy, done, result
  );

  // Unit side.
  modport slave (
    input  op_a, op_b, operation, start, cancel,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational datapath producing the next {HI,LO} for a
//               compute op (multiply, multiply-accumulate, divide).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_t          i_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_pend_hi,
  output logic [WIDTH-1:0] o_pend_lo
);

  logic               w_signed;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_divisor;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = is_signed_op(i_op);

  // Sign- or zero-extend to 2*WIDTH so a plain truncated multiply yields the
  // correct signed or unsigned full-width product.
  assign w_ext_a = {{WIDTH{w_signed & i_op_a[WIDTH-1]}}, i_op_a};
  assign w_ext_b = {{WIDTH{w_signed & i_op_b[WIDTH-1]}}, i_op_b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign w_acc   = {i_hi, i_lo};

  // Divide on magnitudes, then restore signs: quotient negative when signs
  // differ, remainder follows the dividend. MIN / -1 falls out as MIN, 0.
  assign w_neg_a    = w_signed & i_op_a[WIDTH-1];
  assign w_neg_b    = w_signed & i_op_b[WIDTH-1];
  assign w_mag_a    = w_neg_a ? (~i_op_a + WIDTH'(1)) : i_op_a;
  assign w_mag_b    = w_neg_b ? (~i_op_b + WIDTH'(1)) : i_op_b;
  assign w_div_zero = (i_op_b == '0);
  assign w_divisor  = w_div_zero ? WIDTH'(1) : w_mag_b;
  assign w_q_mag    = w_mag_a / w_divisor;
  assign w_r_mag    = w_mag_a % w_divisor;
  assign w_quot     = (w_neg_a ^ w_neg_b) ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
  assign w_rem      = w_neg_a ? (~w_r_mag + WIDTH'(1)) : w_r_mag;

  // Select the pending {HI,LO} for the requested op.
  always_comb begin
    {o_pend_hi, o_pend_lo} = {i_hi, i_lo};
    case (i_op)
      SMUL, UMUL:   {o_pend_hi, o_pend_lo} = w_prod;
      SMADD, UMADD: {o_pend_hi, o_pend_lo} = w_acc + w_prod;
      SMSUB, UMSUB: {o_pend_hi, o_pend_lo} = w_acc - w_prod;
      SDIV, UDIV: begin
        if (w_div_zero) begin
          o_pend_hi = i_op_a;
          o_pend_lo = '1;
        end else begin
          o_pend_hi = w_rem;
          o_pend_lo = w_quot;
        end
      end
      default: {o_pend_hi, o_pend_lo} = {i_hi, i_lo};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_param.sv
`default_nettype none
// ============================================================================
// Module      : mdu_param
// Description : Multi-cycle multiply/divide unit holding HI/LO. Results are
//               staged in pending registers and committed after a per-class
//               latency unless the operation is cancelled first.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_param
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 5,
  parameter int DIV_LATENCY = 10
) (
  input  logic  clock,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int c_cnt_w = $clog2(max_int(MUL_LATENCY, DIV_LATENCY) + 1);
  localparam logic [c_cnt_w-1:0] c_mul_cnt = c_cnt_w'(MUL_LATENCY);
  localparam logic [c_cnt_w-1:0] c_div_cnt = c_cnt_w'(DIV_LATENCY);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

  mdu_state_t       r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic             r_done;

  logic             w_busy;
  logic             w_accept;
  logic [WIDTH-1:0] w_next_hi;
  logic [WIDTH-1:0] w_next_lo;

  assign w_busy   = (r_state == RUN);
  // Cancel always blocks a coincident start, even while idle.
  assign w_accept = bus.start & ~w_busy & ~bus.cancel;

  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .i_op      (bus.operation),
    .i_op_a    (bus.op_a),
    .i_op_b    (bus.op_b),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .o_pend_hi (w_next_hi),
    .o_pend_lo (w_next_lo)
  );

  // Control FSM: accept, count down, then commit or discard pending result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.operation == WRITE_HI) begin
              r_hi <= bus.op_a;
            end else if (bus.operation == WRITE_LO) begin
              r_lo <= bus.op_a;
            end else if (is_compute(bus.operation)) begin
              // Accumulate base is captured here, at the accept edge.
              r_pend_hi <= w_next_hi;
              r_pend_lo <= w_next_lo;
              r_cnt     <= is_div(bus.operation) ? c_div_cnt : c_mul_cnt;
              r_state   <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.cancel) begin
            // Cancel wins even on the final cycle: nothing is committed.
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_cnt == c_one) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;

  // Read data is the current register value with no write bypass.
  always_comb begin
    bus.result = '0;
    if (w_accept) begin
      if (bus.operation == READ_HI) begin
        bus.result = r_hi;
      end else if (bus.operation == READ_LO) begin
        bus.result = r_lo;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_param
// Description : Directed self-checking bench for mdu_param with a result
//               scoreboard and an independent behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_param;
  import mdu_pkg::*;

  localparam int c_mul_lat = 5;
  localparam int c_div_lat = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_param #(
    .WIDTH       (32),
    .MUL_LATENCY (c_mul_lat),
    .DIV_LATENCY (c_div_lat)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] rd_hi;
  logic [31:0] rd_lo;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference for one compute op.
  function automatic logic [63:0] model(mdu_op_t op, logic [31:0] a, logic [31:0] b,
                                        logic [31:0] hi, logic [31:0] lo);
    longint      sa;
    longint      sb;
    logic [63:0] ps;
    logic [63:0] pu;
    int          q;
    int          r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    pu = {32'h0, a} * {32'h0, b};
    case (op)
      SMUL:  return ps;
      UMUL:  return pu;
      SMADD: return {hi, lo} + ps;
      UMADD: return {hi, lo} + pu;
      SMSUB: return {hi, lo} - ps;
      UMSUB: return {hi, lo} - pu;
      SDIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      UDIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic issue(mdu_op_t op, logic [31:0] a, logic [31:0] b);
    @(negedge clock);
    bus.operation = op;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.start     = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic rd(mdu_op_t op, output logic [31:0] v);
    @(negedge clock);
    bus.operation = op;
    bus.start     = 1'b1;
    #1;
    v = bus.result;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wr(mdu_op_t op, logic [31:0] a);
    issue(op, a, 32'h0);
    if (op == WRITE_HI) m_hi = a;
    else m_lo = a;
    chk("write_busy", 32'(bus.busy), 32'h0);
  endtask

  // Issue a compute op, check busy/done timing, then read back HI/LO.
  // inj > 0 drives a stray start in RUN cycle T+inj, which must be ignored.
  task automatic run_op(string tag, mdu_op_t op, logic [31:0] a, logic [31:0] b, int inj);
    int          lat;
    logic [63:0] e;
    lat = is_div(op) ? c_div_lat : c_mul_lat;
    exp_q.push_back(model(op, a, b, m_hi, m_lo));
    issue(op, a, b);
    for (int k = 1; k <= lat; k++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
      chk({tag, "_nodone"}, 32'(bus.done), 32'h0);
      if (k == inj) begin
        bus.operation = UMUL;
        bus.op_a      = 32'd9;
        bus.op_b      = 32'd9;
        bus.start     = 1'b1;
      end
      @(posedge clock);
      #1;
      bus.start = 1'b0;
    end
    chk({tag, "_idle"}, 32'(bus.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'h0, 32'h1);
    end else begin
      e    = exp_q.pop_front();
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    rd(READ_HI, rd_hi);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'h0);
    rd(READ_LO, rd_lo);
    chk({tag, "_hi"}, rd_hi, m_hi);
    chk({tag, "_lo"}, rd_lo, m_lo);
  endtask

  initial begin
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.operation = READ_HI;
    bus.start     = 1'b0;
    bus.cancel    = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_result", bus.result, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    rd(READ_HI, rd_hi);
    chk("rst_read_hi", rd_hi, 32'h0);
    chk("rst_read_busy", 32'(bus.busy), 32'h0);

    // Signed multiply of a negative operand.
    run_op("smul", SMUL, 32'hFFFF_FFFE, 32'd3, 0);
    chk("smul_hi_val", rd_hi, 32'hFFFF_FFFF);
    chk("smul_lo_val", rd_lo, 32'hFFFF_FFFA);

    // Write then accumulate with carry out of LO; stray start at T+3.
    wr(WRITE_HI, 32'h1);
    wr(WRITE_LO, 32'hFFFF_FFFF);
    rd(READ_LO, rd_lo);
    chk("write_lo_read", rd_lo, 32'hFFFF_FFFF);
    run_op("umadd", UMADD, 32'd1, 32'd1, 3);
    chk("umadd_hi_val", rd_hi, 32'h2);
    chk("umadd_lo_val", rd_lo, 32'h0);

    // Division corners.
    run_op("sdiv", SDIV, 32'hFFFF_FFF9, 32'd2, 0);
    chk("sdiv_lo_val", rd_lo, 32'hFFFF_FFFD);
    chk("sdiv_hi_val", rd_hi, 32'hFFFF_FFFF);
    run_op("udiv0", UDIV, 32'd5, 32'd0, 0);
    chk("udiv0_lo_val", rd_lo, 32'hFFFF_FFFF);
    chk("udiv0_hi_val", rd_hi, 32'h5);
    run_op("sdivmin", SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("umul", UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("smsub", SMSUB, 32'd3, 32'hFFFF_FFFC, 0);
    run_op("umsub", UMSUB, 32'h1234_5678, 32'h10, 0);
    run_op("smadd", SMADD, 32'h8000_0000, 32'h8000_0000, 0);

    // Cancel while idle blocks a coincident start.
    @(negedge clock);
    bus.operation = UMUL;
    bus.op_a      = 32'd4;
    bus.op_b      = 32'd4;
    bus.start     = 1'b1;
    bus.cancel    = 1'b1;
    @(posedge clock);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("idle_cancel_busy", 32'(bus.busy), 32'h0);

    // Cancel on the final RUN cycle discards the result.
    wr(WRITE_LO, 32'h1234);
    issue(UDIV, 32'd100, 32'd7);
    for (int k = 1; k <= c_div_lat; k++) begin
      chk("cancel_busy", 32'(bus.busy), 32'h1);
      if (k == c_div_lat) bus.cancel = 1'b1;
      @(posedge clock);
      #1;
      bus.cancel = 1'b0;
    end
    chk("cancel_idle", 32'(bus.busy), 32'h0);
    chk("cancel_nodone", 32'(bus.done), 32'h0);
    @(posedge clock);
    #1;
    chk("cancel_nodone2", 32'(bus.done), 32'h0);
    rd(READ_LO, rd_lo);
    chk("cancel_lo", rd_lo, m_lo);
    rd(READ_HI, rd_hi);
    chk("cancel_hi", rd_hi, m_hi);

    // Asynchronous reset in the middle of RUN.
    issue(SMUL, 32'd7, 32'd7);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    chk("arst_pre_busy", 32'(bus.busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'h0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      chk("arst_nodone", 32'(bus.done), 32'h0);
    end
    rd(READ_HI, rd_hi);
    chk("arst_hi", rd_hi, m_hi);
    rd(READ_LO, rd_lo);
    chk("arst_lo", rd_lo, m_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_param.md
# mdu_param

Parametrised multiply/divide unit for the pipeline EX stage: it holds HI/LO, runs multiply, divide and multiply-accumulate over a programmable number of cycles, and raises `busy` so the control unit stalls dependent instructions. Width and per-class latency are parameters. The block adds two things: a `cancel` input that lets a pipeline flush abort an in-flight operation without corrupting HI/LO, and a one-cycle `done` pulse on commit.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `MUL_LATENCY`, 5: busy cycles for MUL/MADD/MSUB; must be ≥1.
- `DIV_LATENCY`, 10: busy cycles for DIV; must be ≥1.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op_a`  in  WIDTH  rs operand; also the source for WRITE_HI/WRITE_LO.
- `op_b`  in  WIDTH  rt operand.
- `operation`  in  `mdu_op_t` (4)  requested operation.
- `start`  in  1  `operation` is valid this cycle.
- `cancel`  in  1  abort the in-flight operation.
- `busy`  out  1  operation in flight; start requests are ignored.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO commit.
- `result`  out  WIDTH  combinational HI or LO for a read op.

## Operation
- Ops: READ_HI, READ_LO, WRITE_HI, WRITE_LO, SMUL, UMUL, SDIV, UDIV, SMADD, UMADD, SMSUB, UMSUB. Codes 0–7 keep the existing `md_control` encoding.
- Accept condition: `start & ~busy & ~cancel`. Any other `start` has no effect.
- READ_HI/READ_LO:
  - `result` = current HI/LO, combinationally, in the same cycle as the accept.
  - `result` = 0 when no read is accepted.
- WRITE_HI/WRITE_LO: HI/LO ← `op_a` on the accept edge. No busy, no `done`.
- SMUL/UMUL: {HI,LO} ← op_a × op_b, a signed or unsigned 2·WIDTH-bit product.
- SMADD/UMADD: {HI,LO} ← {HI,LO} + product.
- SMSUB/UMSUB: {HI,LO} ← {HI,LO} − product.
- Accumulation is modulo 2^(2·WIDTH). The accumulate base is the HI/LO value at the accept edge.
- SDIV/UDIV: LO ← quotient, HI ← remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO ← all ones, HI ← `op_a`.
  - SDIV of MIN / −1: LO ← MIN, HI ← 0.
- On accept of a compute op, the result is latched into pending registers and a counter is loaded with the latency.
- State machine:
  - IDLE → RUN on accepted compute op.
  - RUN decrements the counter each cycle.
  - RUN with counter = 1 → IDLE, and pending is committed to HI/LO.
  - RUN with `cancel` → IDLE, and pending is discarded.
- `busy` = (state == RUN).
- Boundary rules:
  - `cancel` on the final RUN cycle wins: no commit and no `done`.
  - `cancel` while IDLE has no effect, and it blocks a coincident `start`.
  - Reset in mid-operation discards pending and clears HI/LO.
- Reset values: HI = 0, LO = 0, `busy` = 0, `done` = 0, `result` = 0 (no start), counter = 0, state = IDLE.

## Timing
- Let the accept happen in cycle T, and let L be the latency of the op class.
- `busy` = 1 in cycles T+1 … T+L.
- HI/LO are updated on the edge closing T+L. They are visible, and `busy` = 0, in T+L+1.
- `done` = 1 in T+L+1 only.
- A new op can be accepted in T+L+1. Back-to-back issue rate is therefore one op per L+1 cycles.
- WRITE_HI/WRITE_LO take effect on the edge closing T. A read in T+1 returns the new value.
- A read in the same cycle as a write returns the old value; `result` has no bypass.
- `cancel` sampled in RUN cycle k: `busy` = 0 from k+1, and HI/LO are unchanged.
- The counter width is $clog2(max(MUL_LATENCY, DIV_LATENCY)+1).

## Structure
- Package `mdu_pkg` holds:
  - enum `mdu_op_t` (4-bit);
  - helper function `is_compute(op)`;
  - state enum `mdu_state_t` {IDLE, RUN}.
- Sub-module `mdu_arith` is purely combinational. Inputs: op, op_a, op_b, HI, LO. Outputs: pending HI and LO.
- The top level holds the FSM, counter, HI/LO registers, pending registers and output logic.

## Test plan
Defaults for all scenarios: WIDTH = 32, MUL_LATENCY = 5, DIV_LATENCY = 10.
- Reset, then READ_HI in cycle 1 → `result` = 0, `busy` = 0.
- SMUL 0xFFFFFFFE × 3 accepted in T → `busy` in T+1..T+5, `done` in T+6, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- WRITE_HI 1, WRITE_LO 0xFFFFFFFF, then UMADD 1×1 → HI = 2, LO = 0. A start issued in T+3 is ignored.
- SDIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. UDIV 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- After WRITE_LO 0x1234, start UDIV 100/7, then `cancel` in T+10 → `busy` = 0 in T+11, no `done`, READ_LO = 0x1234.
- Async reset asserted mid-RUN at T+3 → `busy` drops immediately, HI = LO = 0, and no commit follows.
